// File: rtl/fastica_error_check_pkg.sv
// Shared constants, state encoding and helpers for the FastICA convergence/error stage.
package fastica_error_check_pkg;

    localparam int unsigned N        = 4;
    localparam int unsigned NN       = N * N;
    localparam int unsigned AW       = $clog2(NN);
    localparam int unsigned CW       = $clog2(N);
    localparam int unsigned DW       = 16;
    localparam int unsigned FRAC     = 14;
    localparam int unsigned ACCW     = 40;
    localparam int unsigned TOL      = 16;
    localparam int unsigned MAX_ITER = 255;
    localparam int unsigned ITW      = 8;

    localparam logic [DW-1:0] ONE = DW'(1 << FRAC);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} err_state_e;

    function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fastica_error_check_dot_mac.sv
// Registered multiply and per-row accumulate; produces |ONE - |dot|| for each finished row.
module fastica_error_check_dot_mac
    import fastica_error_check_pkg::*;
(
    input  logic          clk_error,
    input  logic          go_error,
    input  logic          clr,
    input  logic          in_valid,
    input  logic          in_last,
    input  logic [DW-1:0] w_new,
    input  logic [DW-1:0] w_old,
    output logic          row_valid,
    output logic [DW-1:0] row_err
);

    logic signed [DW-1:0]   a_q, b_q;
    logic signed [2*DW-1:0] prod_q;
    logic signed [ACCW-1:0] acc_q, prod_ext, acc_sum, dot_full;
    logic                   v1_q, l1_q, v2_q, l2_q;
    logic [DW-1:0]          dot_sat, dot_abs;

    always_ff @(posedge clk_error or negedge go_error) begin
        if (!go_error) begin
            a_q    <= '0;
            b_q    <= '0;
            v1_q   <= 1'b0;
            l1_q   <= 1'b0;
            prod_q <= '0;
            v2_q   <= 1'b0;
            l2_q   <= 1'b0;
            acc_q  <= '0;
        end else if (clr) begin
            a_q    <= '0;
            b_q    <= '0;
            v1_q   <= 1'b0;
            l1_q   <= 1'b0;
            prod_q <= '0;
            v2_q   <= 1'b0;
            l2_q   <= 1'b0;
            acc_q  <= '0;
        end else begin
            a_q    <= w_new;
            b_q    <= w_old;
            v1_q   <= in_valid;
            l1_q   <= in_last;
            prod_q <= (2*DW)'(a_q) * (2*DW)'(b_q);
            v2_q   <= v1_q;
            l2_q   <= v1_q && l1_q;
            if (v2_q) begin
                acc_q <= l2_q ? '0 : acc_sum;
            end
        end
    end

    // Row result is taken combinationally off the final sum so it lands on the row's last edge.
    always_comb begin
        prod_ext = ACCW'(prod_q);
        acc_sum  = acc_q + prod_ext;
        dot_full = acc_sum >>> FRAC;

        if (dot_full[ACCW-1] && !(&dot_full[ACCW-1:DW-1])) begin
            dot_sat = {1'b1, {(DW-1){1'b0}}};
        end else if (!dot_full[ACCW-1] && (|dot_full[ACCW-1:DW-1])) begin
            dot_sat = {1'b0, {(DW-1){1'b1}}};
        end else begin
            dot_sat = dot_full[DW-1:0];
        end

        if (!dot_sat[DW-1]) begin
            dot_abs = dot_sat;
        end else if (dot_sat[DW-2:0] == '0) begin
            dot_abs = {1'b0, {(DW-1){1'b1}}};
        end else begin
            dot_abs = -dot_sat;
        end

        row_err   = (dot_abs >= ONE) ? (dot_abs - ONE) : (ONE - dot_abs);
        row_valid = v2_q && l2_q;
    end

endmodule

// File: rtl/fastica_error_check.sv
// FastICA convergence check: streams W_new/W_old rows, tracks max row error, decides convergence.
module fastica_error_check
    import fastica_error_check_pkg::*;
(
    input  logic           clk_error,
    input  logic           go_error,
    input  logic           en_error,
    output logic           rd_en,
    output logic [AW-1:0]  rd_addr,
    input  logic [DW-1:0]  w_new_data,
    input  logic [DW-1:0]  w_old_data,
    output logic           error_busy,
    output logic           is_converge,
    output logic [DW-1:0]  max_err,
    output logic [ITW-1:0] iter_cnt,
    output logic           timeout
);

    err_state_e     state_q, state_d;
    logic [AW-1:0]  addr_q;
    logic [CW-1:0]  col_q;
    logic [1:0]     drain_q;
    logic           rd_q, rd_last_q, pipe_clr;
    logic           row_valid;
    logic [DW-1:0]  row_err, run_max_q, cur_max, max_err_q;
    logic [ITW-1:0] iter_q;
    logic           timeout_q, conv_q;
    logic           exceed, forced, done_entry, run_start;

    always_ff @(posedge clk_error or negedge go_error) begin
        if (!go_error) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (en_error) state_d = StRun;
            StRun: begin
                if (!en_error)                  state_d = StIdle;
                else if (addr_q == AW'(NN - 1)) state_d = StDrain;
            end
            StDrain: begin
                if (!en_error)            state_d = StIdle;
                else if (drain_q == 2'd2) state_d = StDone;
            end
            StDone:  if (!en_error) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        error_busy = (state_q == StRun) || (state_q == StDrain);
        rd_en      = (state_q == StRun);
        pipe_clr   = (state_q == StIdle);
    end

    always_ff @(posedge clk_error or negedge go_error) begin
        if (!go_error) begin
            addr_q    <= '0;
            col_q     <= '0;
            drain_q   <= 2'd0;
            rd_q      <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            if (state_q == StRun && state_d == StRun) begin
                addr_q <= addr_q + 1'b1;
                col_q  <= (col_q == CW'(N - 1)) ? '0 : col_q + 1'b1;
            end else begin
                addr_q <= '0;
                col_q  <= '0;
            end
            drain_q   <= (state_q == StDrain && state_d == StDrain) ? drain_q + 2'd1 : 2'd0;
            // Tags follow the weight RF's one-cycle read latency.
            rd_q      <= rd_en;
            rd_last_q <= rd_en && (col_q == CW'(N - 1));
        end
    end

    fastica_error_check_dot_mac u_dot_mac (
        .clk_error (clk_error),
        .go_error  (go_error),
        .clr       (pipe_clr),
        .in_valid  (rd_q),
        .in_last   (rd_last_q),
        .w_new     (w_new_data),
        .w_old     (w_old_data),
        .row_valid (row_valid),
        .row_err   (row_err)
    );

    // Fold the row finishing this cycle in, so the last row counts on the DONE edge.
    always_comb begin
        cur_max    = (row_valid && error_busy) ? umax(run_max_q, row_err) : run_max_q;
        exceed     = cur_max > DW'(TOL);
        forced     = exceed && (iter_q == ITW'(MAX_ITER - 1));
        done_entry = (state_q == StDrain) && (state_d == StDone);
        run_start  = (state_q == StIdle) && (state_d == StRun);
    end

    always_ff @(posedge clk_error or negedge go_error) begin
        if (!go_error) begin
            run_max_q <= '0;
            max_err_q <= '0;
            iter_q    <= '0;
            timeout_q <= 1'b0;
            conv_q    <= 1'b0;
        end else begin
            run_max_q <= error_busy ? cur_max : '0;
            if (run_start) begin
                max_err_q <= '0;
                conv_q    <= 1'b0;
            end else if (done_entry) begin
                max_err_q <= cur_max;
                conv_q    <= !exceed || forced;
                timeout_q <= forced;
                if (exceed && !forced && iter_q != {ITW{1'b1}}) begin
                    iter_q <= iter_q + 1'b1;
                end
            end else if (state_q == StDone && state_d == StIdle) begin
                conv_q <= 1'b0;
            end
        end
    end

    assign rd_addr     = addr_q;
    assign is_converge = conv_q;
    assign max_err     = max_err_q;
    assign iter_cnt    = iter_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_fastica_error_check.sv
// Self-checking bench for fastica_error_check: table vectors, random runs vs a row-dot model, corners.
module tb_fastica_error_check;

    logic        clk_error = 1'b0;
    logic        go_error;
    logic        en_error;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [15:0] w_new_data;
    logic [15:0] w_old_data;
    logic        error_busy;
    logic        is_converge;
    logic [15:0] max_err;
    logic [7:0]  iter_cnt;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] wn[16];
    logic signed [15:0] wo[16];
    int m_iter;
    bit m_to;

    typedef struct {
        string       name;
        int          pat;
        logic [15:0] exp_max;
        int          exp_conv;
        int          exp_iter;
    } vec_t;
    vec_t tbl[7];

    fastica_error_check dut (
        .clk_error   (clk_error),
        .go_error    (go_error),
        .en_error    (en_error),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .w_new_data  (w_new_data),
        .w_old_data  (w_old_data),
        .error_busy  (error_busy),
        .is_converge (is_converge),
        .max_err     (max_err),
        .iter_cnt    (iter_cnt),
        .timeout     (timeout)
    );

    initial forever #5 clk_error = ~clk_error;

    // Weight register file: data for a read strobe appears one cycle later.
    initial begin
        logic       r;
        logic [3:0] a;
        w_new_data = '0;
        w_old_data = '0;
        forever begin
            @(negedge clk_error);
            r = rd_en;
            a = rd_addr;
            @(posedge clk_error);
            #1;
            if (r) begin
                w_new_data = wn[a];
                w_old_data = wo[a];
            end else begin
                w_new_data = 16'($urandom);
                w_old_data = 16'($urandom);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic load(input int p);
        for (int k = 0; k < 16; k++) begin
            int row, col;
            row = k / 4;
            col = k % 4;
            wo[k] = (row == col) ? 16'sh4000 : 16'sh0000;
            case (p)
                0: wn[k] = wo[k];
                1: wn[k] = (k == 0) ? 16'shC000 : wo[k];
                2: wn[k] = (col == (row + 1) % 4) ? 16'sh4000 : 16'sh0000;
                3: begin wn[k] = 16'sh7FFF; wo[k] = 16'sh7FFF; end
                4: wn[k] = (row == col) ? 16'sh4010 : 16'sh0000;
                5: wn[k] = (row == col) ? 16'sh4011 : 16'sh0000;
                6: wn[k] = (row == col) ? 16'sh3FF0 : 16'sh0000;
                default: wn[k] = wo[k];
            endcase
        end
    endtask

    task automatic gen_random();
        int mode;
        mode = int'($urandom_range(0, 2));
        for (int k = 0; k < 16; k++) begin
            int v;
            case (mode)
                0: begin wn[k] = 16'($urandom); wo[k] = 16'($urandom); end
                1: begin
                    wo[k] = (k / 4 == k % 4) ? 16'sh4000 : 16'sh0000;
                    if (k / 4 == k % 4) begin
                        v = 16384 + int'($urandom_range(0, 48)) - 24;
                        wn[k] = ($urandom_range(0, 1) == 1) ? 16'(-v) : 16'(v);
                    end else begin
                        wn[k] = 16'(int'($urandom_range(0, 16)) - 8);
                    end
                end
                default: begin wo[k] = 16'($urandom); wn[k] = wo[k]; end
            endcase
        end
    endtask

    // Row errors straight from the definition, plus the iteration/timeout bookkeeping.
    task automatic model_run(output logic [15:0] mx, output int conv);
        longint acc, d;
        int     e;
        bit     exceed, forced;
        mx = '0;
        for (int i = 0; i < 4; i++) begin
            acc = 0;
            for (int j = 0; j < 4; j++) begin
                acc += longint'(wn[i*4+j]) * longint'(wo[i*4+j]);
            end
            d = acc >>> 14;
            if (d > 32767) d = 32767;
            if (d < -32768) d = -32768;
            if (d < 0) d = -d;
            if (d > 32767) d = 32767;
            e = (d > 16384) ? int'(d - 16384) : int'(16384 - d);
            if (e > int'(mx)) mx = 16'(e);
        end
        exceed = int'(mx) > 16;
        forced = exceed && (m_iter == 254);
        conv   = (!exceed || forced) ? 1 : 0;
        m_to   = forced;
        if (exceed && !forced && m_iter < 255) m_iter++;
    endtask

    task automatic do_run(input string nm, output logic [15:0] got_max);
        logic [15:0] exp_max;
        int          exp_conv;
        int          cnt, conv_bad, nreads, first_rd, last_rd;
        bit          first_busy, addr_ok;
        model_run(exp_max, exp_conv);
        @(negedge clk_error);
        en_error = 1'b1;
        cnt = 0; conv_bad = 0; nreads = 0; first_rd = -1; last_rd = -1;
        first_busy = 1'b0; addr_ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_error);
            if (i == 0) first_busy = error_busy;
            if (rd_en) begin
                if (rd_addr != 4'(nreads)) addr_ok = 1'b0;
                if (first_rd < 0) first_rd = i;
                last_rd = i;
                nreads++;
            end
            if (error_busy) begin
                cnt++;
                if (is_converge) conv_bad++;
            end else if (cnt > 0 || i > 3) begin
                break;
            end
        end
        check($sformatf("%s busy_next_cycle", nm), 32'(first_busy), 1);
        check($sformatf("%s busy_cycles", nm), cnt, 19);
        check($sformatf("%s conv_while_busy", nm), conv_bad, 0);
        check($sformatf("%s read_count", nm), nreads, 16);
        check($sformatf("%s read_span", nm), last_rd - first_rd, 15);
        check($sformatf("%s read_addr_order", nm), 32'(addr_ok), 1);
        check($sformatf("%s is_converge", nm), 32'(is_converge), exp_conv);
        check($sformatf("%s max_err", nm), 32'(max_err), 32'(exp_max));
        check($sformatf("%s iter_cnt", nm), 32'(iter_cnt), m_iter);
        check($sformatf("%s timeout", nm), 32'(timeout), 32'(m_to));
        got_max = max_err;
        en_error = 1'b0;
        @(negedge clk_error);
        check($sformatf("%s conv_cleared", nm), 32'(is_converge), 0);
        check($sformatf("%s max_hold", nm), 32'(max_err), 32'(exp_max));
    endtask

    initial begin
        logic [15:0] gm;
        tbl[0] = '{"ident",   0, 16'h0000, 1, 0};
        tbl[1] = '{"neg_row", 1, 16'h0000, 1, 0};
        tbl[2] = '{"perm",    2, 16'h4000, 0, 1};
        tbl[3] = '{"sat7fff", 3, 16'h3FFF, 0, 2};
        tbl[4] = '{"tol_eq",  4, 16'h0010, 1, 2};
        tbl[5] = '{"tol_gt",  5, 16'h0011, 0, 3};
        tbl[6] = '{"tol_lo",  6, 16'h0010, 1, 3};

        go_error = 1'b0;
        en_error = 1'b0;
        load(0);
        repeat (3) @(negedge clk_error);
        check("rst busy", 32'(error_busy), 0);
        check("rst rd_en", 32'(rd_en), 0);
        check("rst outputs", {rd_addr, is_converge, max_err, iter_cnt, timeout}, 0);
        go_error = 1'b1;
        m_iter = 0;
        m_to = 1'b0;
        @(negedge clk_error);

        for (int v = 0; v < 7; v++) begin
            load(tbl[v].pat);
            do_run(tbl[v].name, gm);
            check($sformatf("%s tbl_max", tbl[v].name), 32'(gm), 32'(tbl[v].exp_max));
            check($sformatf("%s tbl_iter", tbl[v].name), 32'(iter_cnt), tbl[v].exp_iter);
        end

        for (int r = 0; r < 20; r++) begin
            gen_random();
            do_run($sformatf("rand%0d", r), gm);
        end

        // Abort: en_error dropped during RUN.
        load(2);
        @(negedge clk_error);
        en_error = 1'b1;
        repeat (8) @(negedge clk_error);
        check("abort pre_busy", 32'(error_busy), 1);
        en_error = 1'b0;
        @(negedge clk_error);
        check("abort busy", 32'(error_busy), 0);
        check("abort rd_en", 32'(rd_en), 0);
        check("abort conv", 32'(is_converge), 0);
        check("abort max_err", 32'(max_err), 0);
        check("abort iter", 32'(iter_cnt), m_iter);
        check("abort timeout", 32'(timeout), 32'(m_to));
        repeat (4) @(negedge clk_error);
        check("abort stays_idle", 32'(error_busy), 0);
        load(0);
        do_run("recover", gm);

        // Async reset in the middle of a run.
        load(2);
        @(negedge clk_error);
        en_error = 1'b1;
        repeat (6) @(negedge clk_error);
        check("midrst pre_busy", 32'(error_busy), 1);
        check("midrst pre_iter_nonzero", 32'(iter_cnt != 0), 1);
        #2;
        go_error = 1'b0;
        #1;
        check("midrst busy", 32'(error_busy), 0);
        check("midrst rd_en", 32'(rd_en), 0);
        check("midrst outputs", {rd_addr, is_converge, max_err, iter_cnt, timeout}, 0);
        en_error = 1'b0;
        @(negedge clk_error);
        go_error = 1'b1;
        m_iter = 0;
        m_to = 1'b0;
        @(negedge clk_error);

        // Forced exit after MAX_ITER-1 non-converged runs.
        load(2);
        for (int r = 0; r < 255; r++) begin
            do_run($sformatf("iter%0d", r), gm);
        end
        check("forced timeout", 32'(timeout), 1);
        check("forced iter_cnt", 32'(iter_cnt), 254);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
